// File: rtl/amber48_decode_stage.sv
// ---------------------------------------------------------------------------
// amber48_pkg / amber48_decode_stage
//
// Purpose:
//   Registered decode stage between fetch and issue. Fetched 48-bit words are
//   buffered in a DEPTH-entry circular queue. The queue head is decoded
//   combinationally into amber48_decode_out_s and moved into an output
//   register that is offered downstream with a valid/ready handshake.
//   The stage also supports pipeline flush, a sticky halt after a trapping
//   decode, optional immediate-shift opcodes, and an occupancy count plus a
//   saturating count of handshaken decodes.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   in_valid_i      fetch word valid
//   in_ready_o      stage accepts a fetch word this cycle
//   in_pc_i         PC of the fetch word (XLEN)
//   in_instr_i      48-bit instruction word
//   flush_i         synchronous pipeline flush
//   decode_valid_o  decode_o holds a valid decode
//   decode_ready_i  downstream consumes decode_o
//   decode_o        decoded instruction (amber48_decode_out_s)
//   halted_o        sticky trap halt active
//   occupancy_o     number of queued entries
//   decoded_cnt_o   handshaken decodes, saturating at all-ones
// ---------------------------------------------------------------------------
package amber48_pkg;

    localparam int AMBER48_XLEN = 48;

    typedef enum logic [2:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_LSL,
        ALU_LSR
    } alu_op_e;

    typedef enum logic [3:0] {
        BR_NONE,
        BR_EQ,
        BR_NE,
        BR_LT_U,
        BR_LT_S,
        BR_GT_U,
        BR_GT_S,
        BR_ZERO,
        BR_NOT_ZERO,
        BR_UNCOND
    } branch_type_e;

    typedef enum logic [1:0] {
        TRAP_NONE,
        TRAP_ILLEGAL
    } trap_cause_e;

    localparam logic [3:0] REG_ZERO = 4'd0;
    localparam logic [3:0] REG_LR   = 4'd15;

    typedef struct packed {
        logic                    valid;
        logic [AMBER48_XLEN-1:0] pc;
        logic [7:0]              opcode;
        alu_op_e                 alu_op;
        branch_type_e            branch_type;
        logic [3:0]              rs1;
        logic [3:0]              rs2;
        logic [3:0]              rd;
        logic [AMBER48_XLEN-1:0] imm;
        logic                    uses_imm;
        logic                    is_load;
        logic                    is_store;
        logic                    is_jump;
        logic                    is_jump_sub;
        logic                    is_return;
        logic                    trap;
        trap_cause_e             trap_cause;
    } amber48_decode_out_s;

endpackage

module amber48_decode_stage
    import amber48_pkg::*;
#(
    parameter int XLEN             = AMBER48_XLEN,
    parameter int DEPTH            = 4,
    parameter bit TRAP_HALT        = 1'b1,
    parameter bit ENABLE_SHIFT_IMM = 1'b0,
    parameter int CNT_W            = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [XLEN-1:0]          in_pc_i,
    input  logic [47:0]              in_instr_i,
    input  logic                     flush_i,
    output logic                     decode_valid_o,
    input  logic                     decode_ready_i,
    output amber48_decode_out_s      decode_o,
    output logic                     halted_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_W-1:0]         decoded_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [XLEN-1:0]     pc_mem    [DEPTH];
    logic [47:0]         instr_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    logic                push;
    logic                load;
    logic                fire;

    logic [XLEN-1:0]     head_pc;
    logic [47:0]         head_instr;
    logic [7:0]          opcode;
    logic [XLEN-1:0]     imm_sext;
    logic [XLEN-1:0]     imm_upper;
    logic [XLEN-1:0]     imm_shamt;
    logic                illegal;
    amber48_decode_out_s dec;

    assign in_ready_o = (occupancy_o < OCC_W'(DEPTH)) && !halted_o && !flush_i;
    assign push       = in_valid_i && in_ready_o;
    assign fire       = decode_valid_o && decode_ready_i;
    // Flush wins over a head load; a halt freezes loading until the next flush.
    assign load       = (occupancy_o != '0) && !halted_o && !flush_i
                        && (!decode_valid_o || decode_ready_i);

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];
    assign opcode     = head_instr[47:40];

    assign imm_sext   = XLEN'($signed(head_instr[39:24]));
    // Upper-immediate places the 24-bit field at the top of the datapath.
    assign imm_upper  = XLEN'(head_instr[39:16]) << (XLEN - 24);
    assign imm_shamt  = XLEN'(head_instr[29:24]);

    // Queue storage; needs no reset because pointers/occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc_i;
            instr_mem[wr_ptr] <= in_instr_i;
        end
    end

    // Combinational decode of the queue head.
    always_comb begin
        dec             = '0;
        illegal         = 1'b0;
        dec.valid       = 1'b1;
        dec.pc          = head_pc;
        dec.opcode      = opcode;
        dec.alu_op      = ALU_PASS;
        dec.branch_type = BR_NONE;
        dec.rs1         = head_instr[23:20];
        dec.rs2         = head_instr[19:16];
        dec.rd          = head_instr[15:12];
        dec.imm         = imm_sext;
        dec.trap_cause  = TRAP_NONE;

        case (opcode)
            8'h00: begin
                if (head_instr == '0) begin
                    illegal = 1'b1;
                end else begin
                    dec.imm      = imm_upper;
                    dec.uses_imm = 1'b1;
                    dec.rs1      = REG_ZERO;
                    dec.rs2      = REG_ZERO;
                end
            end
            8'h10: dec.alu_op = ALU_ADD;
            8'h11: begin dec.alu_op = ALU_ADD; dec.uses_imm = 1'b1; end
            8'h12: dec.alu_op = ALU_SUB;
            8'h13: begin dec.alu_op = ALU_SUB; dec.uses_imm = 1'b1; end
            8'h20: dec.alu_op = ALU_AND;
            8'h21: dec.alu_op = ALU_OR;
            8'h22: dec.alu_op = ALU_XOR;
            8'h23: begin dec.alu_op = ALU_XOR; dec.uses_imm = 1'b1; end
            8'h30: dec.alu_op = ALU_LSL;
            8'h31: dec.alu_op = ALU_LSR;
            8'h32, 8'h33: begin
                if (ENABLE_SHIFT_IMM) begin
                    dec.alu_op   = opcode[0] ? ALU_LSR : ALU_LSL;
                    dec.uses_imm = 1'b1;
                    dec.imm      = imm_shamt;
                end else begin
                    illegal = 1'b1;
                end
            end
            8'h40: begin dec.branch_type = BR_EQ;   dec.rd = REG_ZERO; end
            8'h41: begin dec.branch_type = BR_NE;   dec.rd = REG_ZERO; end
            8'h42: begin dec.branch_type = BR_LT_U; dec.rd = REG_ZERO; end
            8'h43: begin dec.branch_type = BR_LT_S; dec.rd = REG_ZERO; end
            8'h44: begin dec.branch_type = BR_GT_U; dec.rd = REG_ZERO; end
            8'h45: begin dec.branch_type = BR_GT_S; dec.rd = REG_ZERO; end
            8'h46: begin
                dec.branch_type = BR_ZERO;
                dec.rd          = REG_ZERO;
                dec.rs2         = REG_ZERO;
            end
            8'h47: begin
                dec.branch_type = BR_NOT_ZERO;
                dec.rd          = REG_ZERO;
                dec.rs2         = REG_ZERO;
            end
            8'h48: begin
                dec.branch_type = BR_UNCOND;
                dec.rd          = REG_ZERO;
                dec.rs2         = REG_ZERO;
            end
            8'h60: begin dec.is_load = 1'b1; dec.uses_imm = 1'b1; end
            8'h61: begin
                dec.is_store = 1'b1;
                dec.uses_imm = 1'b1;
                dec.rd       = REG_ZERO;
            end
            8'h70, 8'h71: begin
                dec.branch_type = BR_UNCOND;
                dec.is_jump     = 1'b1;
                dec.uses_imm    = 1'b1;
                dec.rs1         = REG_ZERO;
                dec.rs2         = REG_ZERO;
                dec.rd          = REG_ZERO;
                if (opcode[0]) begin
                    dec.is_jump_sub = 1'b1;
                    dec.rd          = REG_LR;
                end
            end
            8'h72: begin
                dec.branch_type = BR_UNCOND;
                dec.is_return   = 1'b1;
                dec.imm         = '0;
                dec.rs2         = REG_ZERO;
                dec.rd          = REG_ZERO;
                // A return with no explicit source register returns through LR.
                if (head_instr[23:20] == REG_ZERO) begin
                    dec.rs1 = REG_LR;
                end
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            dec.trap       = 1'b1;
            dec.trap_cause = TRAP_ILLEGAL;
            dec.rd         = REG_ZERO;
        end
    end

    // Queue pointers, occupancy, output register and sticky halt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occupancy_o    <= '0;
            decode_valid_o <= 1'b0;
            halted_o       <= 1'b0;
            decode_o       <= '0;
        end else if (flush_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occupancy_o    <= '0;
            decode_valid_o <= 1'b0;
            halted_o       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                decode_o       <= dec;
                decode_valid_o <= 1'b1;
                rd_ptr         <= rd_ptr + 1'b1;
                if (TRAP_HALT && dec.trap) begin
                    halted_o <= 1'b1;
                end
            end else if (fire) begin
                decode_valid_o <= 1'b0;
            end
            case ({push, load})
                2'b10:   occupancy_o <= occupancy_o + 1'b1;
                2'b01:   occupancy_o <= occupancy_o - 1'b1;
                default: occupancy_o <= occupancy_o;
            endcase
        end
    end

    // Handshake counter; a handshake in a flush cycle still counts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            decoded_cnt_o <= '0;
        end else if (fire && (decoded_cnt_o != '1)) begin
            decoded_cnt_o <= decoded_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_amber48_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_amber48_decode_stage
//
// Purpose:
//   Self-checking bench for amber48_decode_stage. A behavioural model (a
//   queue of fetched words, an output slot, a halt flag and a counter) is
//   stepped every cycle alongside the DUT; decodes are produced from the
//   opcode rules directly. A second instance with immediate shifts enabled
//   and a 3-bit counter covers the shift-immediate decode and saturation.
// ---------------------------------------------------------------------------
module tb_amber48_decode_stage;
    import amber48_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    typedef struct {
        logic [47:0] pc;
        logic [47:0] instr;
    } entry_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [47:0]         in_pc;
    logic [47:0]         in_instr;
    logic                flush;
    logic                decode_valid;
    logic                decode_ready;
    amber48_decode_out_s decode_out;
    logic                halted;
    logic [2:0]          occupancy;
    logic [CNT_W-1:0]    decoded_cnt;

    logic                s_valid;
    logic                s_ready;
    logic [47:0]         s_pc;
    logic [47:0]         s_instr;
    logic                s_flush;
    logic                s_decode_valid;
    logic                s_decode_ready;
    amber48_decode_out_s s_decode_out;
    logic                s_halted;
    logic [2:0]          s_occupancy;
    logic [2:0]          s_cnt;

    int                  checkCount = 0;
    int                  failCount  = 0;

    entry_t              modelQueue[$];
    bit                  modelValid;
    bit                  modelHalted;
    amber48_decode_out_s modelOut;
    int                  modelCnt;

    // 100 MHz-style free-running clock shared by both instances.
    always #5 clk = ~clk;

    amber48_decode_stage #(
        .XLEN(48), .DEPTH(DEPTH), .TRAP_HALT(1'b1),
        .ENABLE_SHIFT_IMM(1'b0), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_pc_i(in_pc), .in_instr_i(in_instr),
        .flush_i(flush),
        .decode_valid_o(decode_valid), .decode_ready_i(decode_ready),
        .decode_o(decode_out), .halted_o(halted),
        .occupancy_o(occupancy), .decoded_cnt_o(decoded_cnt)
    );

    amber48_decode_stage #(
        .XLEN(48), .DEPTH(DEPTH), .TRAP_HALT(1'b1),
        .ENABLE_SHIFT_IMM(1'b1), .CNT_W(3)
    ) dutShift (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(s_valid), .in_ready_o(s_ready),
        .in_pc_i(s_pc), .in_instr_i(s_instr),
        .flush_i(s_flush),
        .decode_valid_o(s_decode_valid), .decode_ready_i(s_decode_ready),
        .decode_o(s_decode_out), .halted_o(s_halted),
        .occupancy_o(s_occupancy), .decoded_cnt_o(s_cnt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference decode, written from the opcode rules with a branch table.
    function automatic amber48_decode_out_s refDecode(input logic [47:0] pc,
                                                      input logic [47:0] w,
                                                      input bit shiftEn);
        amber48_decode_out_s r;
        logic [7:0]   op;
        bit           legal;
        branch_type_e brTable [9];
        alu_op_e      logicTable [4];
        brTable    = '{BR_EQ, BR_NE, BR_LT_U, BR_LT_S, BR_GT_U, BR_GT_S,
                       BR_ZERO, BR_NOT_ZERO, BR_UNCOND};
        logicTable = '{ALU_AND, ALU_OR, ALU_XOR, ALU_XOR};
        op    = w[47:40];
        legal = 1'b1;
        r             = '0;
        r.valid       = 1'b1;
        r.pc          = pc;
        r.opcode      = op;
        r.alu_op      = ALU_PASS;
        r.branch_type = BR_NONE;
        r.trap_cause  = TRAP_NONE;
        r.rs1         = w[23:20];
        r.rs2         = w[19:16];
        r.rd          = w[15:12];
        r.imm         = {{32{w[39]}}, w[39:24]};
        if (op == 8'h00) begin
            if (w == 48'h0) legal = 1'b0;
            else begin
                r.imm = {w[39:16], 24'h000000};
                r.uses_imm = 1'b1;
                r.rs1 = 4'd0;
                r.rs2 = 4'd0;
            end
        end else if (op >= 8'h10 && op <= 8'h13) begin
            r.alu_op   = (op >= 8'h12) ? ALU_SUB : ALU_ADD;
            r.uses_imm = (op == 8'h11 || op == 8'h13);
        end else if (op >= 8'h20 && op <= 8'h23) begin
            r.alu_op   = logicTable[op - 8'h20];
            r.uses_imm = (op == 8'h23);
        end else if (op == 8'h30 || op == 8'h31) begin
            r.alu_op = (op == 8'h30) ? ALU_LSL : ALU_LSR;
        end else if (op == 8'h32 || op == 8'h33) begin
            if (!shiftEn) legal = 1'b0;
            else begin
                r.alu_op   = (op == 8'h32) ? ALU_LSL : ALU_LSR;
                r.uses_imm = 1'b1;
                r.imm      = 48'(w[29:24]);
            end
        end else if (op >= 8'h40 && op <= 8'h48) begin
            r.branch_type = brTable[op - 8'h40];
            r.rd = 4'd0;
            if (op >= 8'h46) r.rs2 = 4'd0;
        end else if (op == 8'h60) begin
            r.is_load = 1'b1;
            r.uses_imm = 1'b1;
        end else if (op == 8'h61) begin
            r.is_store = 1'b1;
            r.uses_imm = 1'b1;
            r.rd = 4'd0;
        end else if (op == 8'h70 || op == 8'h71) begin
            r.branch_type = BR_UNCOND;
            r.is_jump     = 1'b1;
            r.uses_imm    = 1'b1;
            r.rs1         = 4'd0;
            r.rs2         = 4'd0;
            r.rd          = (op == 8'h71) ? 4'd15 : 4'd0;
            r.is_jump_sub = (op == 8'h71);
        end else if (op == 8'h72) begin
            r.branch_type = BR_UNCOND;
            r.is_return   = 1'b1;
            r.imm         = 48'h0;
            r.rs2         = 4'd0;
            r.rd          = 4'd0;
            if (w[23:20] == 4'd0) r.rs1 = 4'd15;
        end else begin
            legal = 1'b0;
        end
        if (!legal) begin
            r.trap       = 1'b1;
            r.trap_cause = TRAP_ILLEGAL;
            r.rd         = 4'd0;
        end
        return r;
    endfunction

    function automatic logic [47:0] rand48();
        return {16'($urandom), $urandom};
    endfunction

    // Mostly legal words; occasional random opcodes and all-zero words.
    function automatic logic [47:0] randWord();
        logic [7:0] legalOps [27];
        logic [47:0] w;
        legalOps = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22,
                     8'h23, 8'h30, 8'h31, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44,
                     8'h45, 8'h46, 8'h47, 8'h48, 8'h60, 8'h61, 8'h70, 8'h71,
                     8'h72, 8'h72, 8'h32};
        w = rand48();
        if ($urandom_range(0, 79) == 0) return 48'h0;
        if ($urandom_range(0, 29) != 0) w[47:40] = legalOps[$urandom_range(0, 25)];
        else if ($urandom_range(0, 1) == 0) w[47:40] = 8'h32;
        return w;
    endfunction

    // One cycle: drive inputs, compare all outputs with the model, advance both.
    task automatic applyStimulus(input bit iv, input logic [47:0] pc,
                                 input logic [47:0] w, input bit fl,
                                 input bit dr);
        bit expReady;
        bit doLoad;
        bit doFire;
        in_valid     = iv;
        in_pc        = pc;
        in_instr     = w;
        flush        = fl;
        decode_ready = dr;
        #1;
        expReady = (modelQueue.size() < DEPTH) && !modelHalted && !fl;
        checkOutput("in_ready", 256'(in_ready), 256'(expReady));
        checkOutput("decode_valid", 256'(decode_valid), 256'(modelValid));
        checkOutput("halted", 256'(halted), 256'(modelHalted));
        checkOutput("occupancy", 256'(occupancy), 256'(modelQueue.size()));
        checkOutput("decoded_cnt", 256'(decoded_cnt), 256'(modelCnt));
        if (modelValid) checkOutput("decode_o", 256'(decode_out), 256'(modelOut));

        doFire = modelValid && dr;
        if (doFire && modelCnt < 65535) modelCnt++;
        if (fl) begin
            modelQueue.delete();
            modelValid  = 1'b0;
            modelHalted = 1'b0;
        end else begin
            doLoad = (modelQueue.size() > 0) && !modelHalted && (!modelValid || dr);
            if (doLoad) begin
                modelOut   = refDecode(modelQueue[0].pc, modelQueue[0].instr, 1'b0);
                void'(modelQueue.pop_front());
                modelValid = 1'b1;
                if (modelOut.trap) modelHalted = 1'b1;
            end else if (doFire) begin
                modelValid = 1'b0;
            end
            if (iv && expReady) modelQueue.push_back('{pc: pc, instr: w});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cntStart;
        rst_n = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; decode_ready = 1'b0;
        s_valid = 1'b0; s_pc = 48'h200; s_instr = '0; s_flush = 1'b0; s_decode_ready = 1'b1;
        modelValid = 1'b0; modelHalted = 1'b0; modelOut = '0; modelCnt = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset_decode_o", 256'(decode_out), 256'(0));
        rst_n = 1'b1;

        // Shift-immediate instance: LSL #5 decode and 3-bit counter saturation.
        s_valid = 1'b1;
        s_instr = 48'h32_0005_000000;
        repeat (2) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("shift_valid", 256'(s_decode_valid), 256'(1));
        checkOutput("shift_alu", 256'(s_decode_out.alu_op), 256'(ALU_LSL));
        checkOutput("shift_imm", 256'(s_decode_out.imm), 256'(5));
        checkOutput("shift_uses_imm", 256'(s_decode_out.uses_imm), 256'(1));
        checkOutput("shift_trap", 256'(s_decode_out.trap), 256'(0));
        repeat (12) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("shift_cnt_sat", 256'(s_cnt), 256'(7));
        s_valid = 1'b0;
        repeat (4) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("shift_occ", 256'(s_occupancy), 256'(0));
        checkOutput("shift_halted", 256'(s_halted), 256'(0));
        checkOutput("shift_ready", 256'(s_ready), 256'(1));

        // First decode latency: push at edge N, valid after edge N+1.
        applyStimulus(1'b1, 48'h100, 48'h10_0000_120000, 1'b0, 1'b1);
        checkOutput("lat_not_yet", 256'(decode_valid), 256'(0));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("lat_valid", 256'(decode_valid), 256'(1));
        checkOutput("add_alu", 256'(decode_out.alu_op), 256'(ALU_ADD));
        checkOutput("add_rs1", 256'(decode_out.rs1), 256'(1));
        checkOutput("add_rs2", 256'(decode_out.rs2), 256'(2));
        checkOutput("add_pc", 256'(decode_out.pc), 256'(48'h100));
        checkOutput("add_occ", 256'(occupancy), 256'(0));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

        // Back-pressure: fill the queue behind a stalled output.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 48'h1000 + 48'(i), {8'h11, 40'(i) << 24}, 1'b0, 1'b0);
        checkOutput("bp_full_occ", 256'(occupancy), 256'(4));
        checkOutput("bp_not_ready", 256'(in_ready), 256'(0));
        checkOutput("bp_hold_pc", 256'(decode_out.pc), 256'(48'h1000));
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("bp_cnt", 256'(decoded_cnt), 256'(6));

        // Upper immediate, then an all-zero word that traps and halts.
        applyStimulus(1'b1, 48'h300, 48'h00_FFFF_FF0000, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("upper_imm", 256'(decode_out.imm), 256'(48'hFFFFFF000000));
        checkOutput("upper_uses_imm", 256'(decode_out.uses_imm), 256'(1));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 48'h400, 48'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 48'h404, 48'h10_0000_340000, 1'b0, 1'b0);
        checkOutput("zero_trap", 256'(decode_out.trap), 256'(1));
        checkOutput("zero_cause", 256'(decode_out.trap_cause), 256'(TRAP_ILLEGAL));
        checkOutput("zero_halted", 256'(halted), 256'(1));
        checkOutput("zero_not_ready", 256'(in_ready), 256'(0));

        // Flush while halted, with a word offered in the same cycle.
        applyStimulus(1'b1, 48'h408, 48'h10_0000_560000, 1'b1, 1'b0);
        checkOutput("flush_occ", 256'(occupancy), 256'(0));
        checkOutput("flush_valid", 256'(decode_valid), 256'(0));
        checkOutput("flush_halted", 256'(halted), 256'(0));

        // 0x32 is illegal on the default instance.
        applyStimulus(1'b1, 48'h500, 48'h32_0005_000000, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("noshift_cause", 256'(decode_out.trap_cause), 256'(TRAP_ILLEGAL));
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);

        // Return through the link register.
        applyStimulus(1'b1, 48'h600, 48'h72_1234_000000, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("ret_rs1", 256'(decode_out.rs1), 256'(REG_LR));
        checkOutput("ret_is_return", 256'(decode_out.is_return), 256'(1));
        checkOutput("ret_imm", 256'(decode_out.imm), 256'(0));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

        // Sustained push and pop every cycle.
        cntStart = modelCnt;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, rand48(), {8'h10 + 8'($urandom_range(0, 3)), 40'(rand48())},
                          1'b0, 1'b1);
            checkOutput("b2b_occ", 256'(occupancy), 256'(1));
        end
        checkOutput("b2b_cnt", 256'(decoded_cnt), 256'(cntStart + 98));
        repeat (4) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

        // Randomized traffic with back-pressure and occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, rand48(), randWord(),
                          $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
